// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants: default widths, frame lengths, nominal prescales
// and the 2-of-3 vote used by the bit sampler.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W_DEF   = 6;
  localparam int unsigned BIT_CNT_W_DEF    = 4;

  localparam int unsigned FRAME_BITS_NOPAR = 10;
  localparam int unsigned FRAME_BITS_PAR   = 11;

  typedef enum logic [5:0] {
    PRESCALE_X8  = 6'd8,
    PRESCALE_X16 = 6'd16,
    PRESCALE_X32 = 6'd32
  } prescale_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter for the UART RX sampler.
// Clears while EN is low, wraps edges at Prescale-1, saturates the bit count.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] edge_max;
  logic                  last_edge;

  always_comb begin
    edge_max  = Prescale - PRESCALE_W'(1);
    last_edge = (edge_cnt == edge_max);
    bit_done  = EN & last_edge;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!EN) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (last_edge) begin
      edge_cnt <= '0;
      if (bit_cnt != '1) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX bit sampler: three mid-bit samples, registered majority vote and strobes.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer first.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done
);

  logic                  rx_s;
  logic                  s0, s1, s2;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] pt_s0, pt_s1, pt_s2, pt_vote;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  always_comb rx_s = sync_q[1];
`else
  always_comb rx_s = RX_IN;
`endif

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .Prescale (Prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done)
  );

  // Sample points straddle mid-bit; Prescale >= 6 keeps H-2 non-negative.
  always_comb begin
    half    = Prescale >> 1;
    pt_s0   = half - PRESCALE_W'(2);
    pt_s1   = half - PRESCALE_W'(1);
    pt_s2   = half;
    pt_vote = half + PRESCALE_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      s2           <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else if (!EN) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      s2           <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (edge_cnt == pt_s0) s0 <= rx_s;
      if (edge_cnt == pt_s1) s1 <= rx_s;
      if (edge_cnt == pt_s2) s2 <= rx_s;
      if (edge_cnt == pt_vote) begin
        sampled_bit  <= maj3(s0, s1, s2);
        sample_valid <= 1'b1;
      end
    end
  end

endmodule
